// File: rtl/enh_demux.sv
// rtl/enh_demux.sv - two-way buffered packet distribution node
//
// Purpose:
//   Steers each valid upstream packet to one of two output FIFOs using a
//   single address bit of the payload. Each output is a first-word-fall-
//   through FIFO of depth 2**log_buffer_len with valid/full flow control.
//   Instances cascade into a binary distribution tree, each tree level
//   choosing its own steering bit through sel_bit.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   in       in   upstream packet, MSB is valid
//   full_in  out  stall to upstream (combinational from in and counts)
//   out_1    out  head of FIFO 1 (steering bit 0), zero when empty
//   out_2    out  head of FIFO 2 (steering bit 1), zero when empty
//   full_1   in   downstream of out_1 cannot accept
//   full_2   in   downstream of out_2 cannot accept

module enh_demux #(
    parameter int word_width     = 22,
    parameter int val_bit        = 1,
    parameter int log_buffer_len = 3,
    parameter int sel_bit        = 21
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [val_bit+word_width-1:0] in,
    output logic                          full_in,
    output logic [val_bit+word_width-1:0] out_1,
    output logic [val_bit+word_width-1:0] out_2,
    input  logic                          full_1,
    input  logic                          full_2
);

    localparam int W     = val_bit + word_width;
    localparam int LB    = log_buffer_len;
    localparam int DEPTH = 1 << LB;
    localparam logic [LB:0] CNT_FULL = DEPTH[LB:0];

    logic       in_valid;
    logic       tgt;
    logic [1:0] full_out;
    logic [1:0] is_full;
    logic [1:0] nonempty;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0][W-1:0] head;

    // Only the top bit of the valid field is interpreted.
    assign in_valid = in[W-1];
    assign tgt      = in[sel_bit];
    assign full_out = {full_2, full_1};

    // Uses registered counts only, so a pop in the same cycle cannot
    // free a slot for this cycle's push; upstream simply retries.
    assign full_in = in_valid & (tgt ? is_full[1] : is_full[0]);

    for (genvar k = 0; k < 2; k++) begin : g_fifo
        logic [W-1:0]  mem_q [DEPTH];
        logic [LB-1:0] wr_ptr_q;
        logic [LB-1:0] rd_ptr_q;
        logic [LB:0]   count_q;
        logic [LB:0]   count_d;

        assign is_full[k]  = (count_q == CNT_FULL);
        assign nonempty[k] = (count_q != '0);
        assign push[k]     = in_valid & (tgt == 1'(k)) & ~is_full[k];
        // An empty FIFO never pops, whatever its downstream full says.
        assign pop[k]      = nonempty[k] & ~full_out[k];

        always_comb begin
            count_d = count_q;
            if (push[k] && !pop[k]) begin
                count_d = count_q + 1'b1;
            end else if (pop[k] && !push[k]) begin
                count_d = count_q - 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push[k]) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop[k]) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                count_q <= count_d;
            end
        end

        // Storage is qualified by count, so it needs no reset.
        always_ff @(posedge clk) begin
            if (push[k]) begin
                mem_q[wr_ptr_q] <= in;
            end
        end

        // Output comes only from registered state; empty shows all zeros.
        assign head[k] = nonempty[k] ? mem_q[rd_ptr_q] : '0;
    end

    assign out_1 = head[0];
    assign out_2 = head[1];

endmodule

// File: tb/tb_enh_demux.sv
// tb/tb_enh_demux.sv - directed self-checking bench for enh_demux

module tb_enh_demux;

    logic        clk;
    logic        rst;
    logic [22:0] pkt_in;
    logic        full_in;
    logic [22:0] out_1;
    logic [22:0] out_2;
    logic        full_1;
    logic        full_2;

    int checks;
    int errors;

    enh_demux dut (
        .clk     (clk),
        .rst     (rst),
        .in      (pkt_in),
        .full_in (full_in),
        .out_1   (out_1),
        .out_2   (out_2),
        .full_1  (full_1),
        .full_2  (full_2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst    = 1'b0;
        pkt_in = 23'h600ABC;
        #3;
        checks++;
        if (out_1 !== 23'h0) begin
            errors++;
            $display("FAIL reset_out_1 got %h want %h", out_1, 23'h0);
        end
        checks++;
        if (out_2 !== 23'h0) begin
            errors++;
            $display("FAIL reset_out_2 got %h want %h", out_2, 23'h0);
        end
        checks++;
        if (full_in !== 1'b0) begin
            errors++;
            $display("FAIL reset_full_in got %b want 0", full_in);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        pkt_in = 23'h0;
        checks++;
        if (out_2 !== 23'h600ABC) begin
            errors++;
            $display("FAIL first_push_out_2 got %h want %h", out_2, 23'h600ABC);
        end
        checks++;
        if (out_1 !== 23'h0) begin
            errors++;
            $display("FAIL first_push_out_1 got %h want %h", out_1, 23'h0);
        end
        tick();
        checks++;
        if (out_2 !== 23'h0) begin
            errors++;
            $display("FAIL first_drain_out_2 got %h want %h", out_2, 23'h0);
        end
    endtask

    task automatic test_steering;
        logic [22:0] stim [5];
        logic [22:0] exp1 [5];
        logic [22:0] exp2 [5];
        stim = '{23'h400001, 23'h600002, 23'h400003, 23'h600004, 23'h000000};
        exp1 = '{23'h400001, 23'h000000, 23'h400003, 23'h000000, 23'h000000};
        exp2 = '{23'h000000, 23'h600002, 23'h000000, 23'h600004, 23'h000000};
        full_1 = 1'b0;
        full_2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pkt_in = stim[i];
            tick();
            checks++;
            if (out_1 !== exp1[i]) begin
                errors++;
                $display("FAIL steer_out_1[%0d] got %h want %h", i, out_1, exp1[i]);
            end
            checks++;
            if (out_2 !== exp2[i]) begin
                errors++;
                $display("FAIL steer_out_2[%0d] got %h want %h", i, out_2, exp2[i]);
            end
        end
        pkt_in = 23'h0;
    endtask

    task automatic test_fill_wrap;
        full_1 = 1'b1;
        full_2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pkt_in = 23'h400010 + 23'(i);
            tick();
        end
        pkt_in = 23'h400020;
        #1;
        checks++;
        if (full_in !== 1'b1) begin
            errors++;
            $display("FAIL fill_full_in got %b want 1", full_in);
        end
        pkt_in = 23'h600030;
        #1;
        checks++;
        if (full_in !== 1'b0) begin
            errors++;
            $display("FAIL fill_other_full_in got %b want 0", full_in);
        end
        tick();
        pkt_in = 23'h0;
        checks++;
        if (out_2 !== 23'h600030) begin
            errors++;
            $display("FAIL fill_other_out_2 got %h want %h", out_2, 23'h600030);
        end
        checks++;
        if (out_1 !== 23'h400010) begin
            errors++;
            $display("FAIL fill_head_out_1 got %h want %h", out_1, 23'h400010);
        end
        full_1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_1 !== 23'h400010 + 23'(i)) begin
                errors++;
                $display("FAIL drain_out_1[%0d] got %h want %h", i, out_1, 23'h400010 + 23'(i));
            end
            tick();
        end
        checks++;
        if (out_1 !== 23'h0) begin
            errors++;
            $display("FAIL drain_empty_out_1 got %h want %h", out_1, 23'h0);
        end
        checks++;
        if (out_2 !== 23'h0) begin
            errors++;
            $display("FAIL drain_empty_out_2 got %h want %h", out_2, 23'h0);
        end
    endtask

    task automatic test_full_pop;
        logic [22:0] exp [8];
        full_1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pkt_in = 23'h400040 + 23'(i);
            tick();
        end
        full_1 = 1'b0;
        pkt_in = 23'h400050;
        #1;
        checks++;
        if (full_in !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_refused got %b want 1", full_in);
        end
        tick();
        checks++;
        if (out_1 !== 23'h400041) begin
            errors++;
            $display("FAIL fullpop_head got %h want %h", out_1, 23'h400041);
        end
        checks++;
        if (full_in !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_retry_full_in got %b want 0", full_in);
        end
        full_1 = 1'b1;
        tick();
        pkt_in = 23'h400051;
        #1;
        checks++;
        if (full_in !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_count8 got %b want 1", full_in);
        end
        pkt_in = 23'h0;
        full_1 = 1'b0;
        exp = '{23'h400041, 23'h400042, 23'h400043, 23'h400044,
                23'h400045, 23'h400046, 23'h400047, 23'h400050};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_1 !== exp[i]) begin
                errors++;
                $display("FAIL fullpop_drain[%0d] got %h want %h", i, out_1, exp[i]);
            end
            tick();
        end
        checks++;
        if (out_1 !== 23'h0) begin
            errors++;
            $display("FAIL fullpop_empty got %h want %h", out_1, 23'h0);
        end
    endtask

    task automatic test_backpressure;
        full_2 = 1'b1;
        pkt_in = 23'h6000AA;
        tick();
        pkt_in = 23'h6000BB;
        tick();
        pkt_in = 23'h0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_2 !== 23'h6000AA) begin
                errors++;
                $display("FAIL hold_out_2[%0d] got %h want %h", i, out_2, 23'h6000AA);
            end
            tick();
        end
        full_2 = 1'b0;
        tick();
        checks++;
        if (out_2 !== 23'h6000BB) begin
            errors++;
            $display("FAIL hold_advance got %h want %h", out_2, 23'h6000BB);
        end
        tick();
        checks++;
        if (out_2 !== 23'h0) begin
            errors++;
            $display("FAIL hold_empty got %h want %h", out_2, 23'h0);
        end
    endtask

    task automatic test_mid_reset;
        full_1 = 1'b1;
        full_2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pkt_in = 23'h400060 + 23'(i);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            pkt_in = 23'h600070 + 23'(i);
            tick();
        end
        pkt_in = 23'h0;
        checks++;
        if (out_1 !== 23'h400060 || out_2 !== 23'h600070) begin
            errors++;
            $display("FAIL midrst_pre got %h/%h want %h/%h", out_1, out_2, 23'h400060, 23'h600070);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_1 !== 23'h0) begin
            errors++;
            $display("FAIL midrst_out_1 got %h want %h", out_1, 23'h0);
        end
        checks++;
        if (out_2 !== 23'h0) begin
            errors++;
            $display("FAIL midrst_out_2 got %h want %h", out_2, 23'h0);
        end
        #2;
        rst = 1'b1;
        full_1 = 1'b0;
        full_2 = 1'b0;
        tick();
        checks++;
        if (out_1 !== 23'h0 || out_2 !== 23'h0) begin
            errors++;
            $display("FAIL midrst_stale got %h/%h want 0/0", out_1, out_2);
        end
        pkt_in = 23'h400099;
        tick();
        pkt_in = 23'h0;
        checks++;
        if (out_1 !== 23'h400099) begin
            errors++;
            $display("FAIL midrst_repush got %h want %h", out_1, 23'h400099);
        end
        tick();
        checks++;
        if (out_1 !== 23'h0) begin
            errors++;
            $display("FAIL midrst_final got %h want %h", out_1, 23'h0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        pkt_in = 23'h0;
        full_1 = 1'b0;
        full_2 = 1'b0;
        test_reset();
        test_steering();
        test_fill_wrap();
        test_full_pop();
        test_backpressure();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
